// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline with a memory-wait watchdog.
// Optional perf counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 5
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  ID_rs1,
    input  logic [4:0]  ID_rs2,
    input  logic        ID_uses_rs1,
    input  logic        ID_uses_rs2,
    input  logic [4:0]  EX_rd,
    input  logic        EX_mem_read,
    input  logic        EX_branch_taken,
    input  logic        imem_busy,
    input  logic        dmem_busy,
    output logic        PC_write_en,
    output logic        IF_ID_write_en,
    output logic        IF_ID_flush,
    output logic        ID_EX_write_en,
    output logic        ID_EX_flush,
    output logic        EX_MEM_write_en,
    output logic        MEM_WB_flush,
    output logic [1:0]  stall_state,
    output logic        timeout,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        IWAIT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             rs1_hit;
    logic             rs2_hit;
    logic             load_use;
    logic             br_fire;

    assign rs1_hit  = ID_uses_rs1 && (ID_rs1 == EX_rd);
    assign rs2_hit  = ID_uses_rs2 && (ID_rs2 == EX_rd);
    assign load_use = EX_mem_read && (EX_rd != 5'd0) && (rs1_hit || rs2_hit);
    assign br_fire  = !dmem_busy && EX_branch_taken;

    // One event per cycle; lower-priority events retry next cycle.
    always_comb begin
        PC_write_en     = 1'b1;
        IF_ID_write_en  = 1'b1;
        IF_ID_flush     = 1'b0;
        ID_EX_write_en  = 1'b1;
        ID_EX_flush     = 1'b0;
        EX_MEM_write_en = 1'b1;
        MEM_WB_flush    = 1'b0;
        if (RESET) begin
            PC_write_en     = 1'b0;
            IF_ID_write_en  = 1'b0;
            IF_ID_flush     = 1'b1;
            ID_EX_write_en  = 1'b0;
            ID_EX_flush     = 1'b1;
            EX_MEM_write_en = 1'b0;
            MEM_WB_flush    = 1'b1;
        end else if (dmem_busy) begin
            PC_write_en     = 1'b0;
            IF_ID_write_en  = 1'b0;
            ID_EX_write_en  = 1'b0;
            EX_MEM_write_en = 1'b0;
            MEM_WB_flush    = 1'b1;
        end else if (EX_branch_taken) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (load_use) begin
            PC_write_en    = 1'b0;
            IF_ID_write_en = 1'b0;
            ID_EX_flush    = 1'b1;
        end else if (imem_busy) begin
            PC_write_en = 1'b0;
            IF_ID_flush = 1'b1;
        end
    end

    // Next state depends only on the busy lines; unused code 3 falls to RUN.
    always_comb begin
        state_nxt = RUN;
        if (dmem_busy)
            state_nxt = DWAIT;
        else if (imem_busy)
            state_nxt = IWAIT;
    end

    always_comb begin
        cnt_nxt = '0;
        if (state_nxt == state && state != RUN) begin
            if (wait_cnt == CNT_W'(MAX_WAIT))
                cnt_nxt = wait_cnt;
            else
                cnt_nxt = wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= RUN;
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= cnt_nxt;
            if (cnt_nxt == CNT_W'(MAX_WAIT))
                timeout <= 1'b1;
        end
    end

    assign stall_state = state;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!PC_write_en)
                stall_q <= stall_q + 32'd1;
            if (br_fire)
                flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_q;
`else
    logic unused_br;
    assign unused_br    = br_fire;
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// Control vector order: PC_we, IF_ID_we, IF_ID_fl, ID_EX_we, ID_EX_fl, EX_MEM_we, MEM_WB_fl.
module tb_pipeline_hazard_ctrl;

    logic        CLK;
    logic        RESET;
    logic [4:0]  ID_rs1;
    logic [4:0]  ID_rs2;
    logic        ID_uses_rs1;
    logic        ID_uses_rs2;
    logic [4:0]  EX_rd;
    logic        EX_mem_read;
    logic        EX_branch_taken;
    logic        imem_busy;
    logic        dmem_busy;
    logic        PC_write_en;
    logic        IF_ID_write_en;
    logic        IF_ID_flush;
    logic        ID_EX_write_en;
    logic        ID_EX_flush;
    logic        EX_MEM_write_en;
    logic        MEM_WB_flush;
    logic [1:0]  stall_state;
    logic        timeout;
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;
    logic [6:0]  ctl;

    int vectors = 0;
    int miscompares = 0;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [6:0] C_DEF  = 7'b1101010;
    localparam logic [6:0] C_RST  = 7'b0010101;
    localparam logic [6:0] C_DMEM = 7'b0000001;
    localparam logic [6:0] C_BR   = 7'b1111110;
    localparam logic [6:0] C_LU   = 7'b0001110;
    localparam logic [6:0] C_IMEM = 7'b0111010;

    pipeline_hazard_ctrl #(.MAX_WAIT(16), .CNT_W(5)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .ID_rs1(ID_rs1),
        .ID_rs2(ID_rs2),
        .ID_uses_rs1(ID_uses_rs1),
        .ID_uses_rs2(ID_uses_rs2),
        .EX_rd(EX_rd),
        .EX_mem_read(EX_mem_read),
        .EX_branch_taken(EX_branch_taken),
        .imem_busy(imem_busy),
        .dmem_busy(dmem_busy),
        .PC_write_en(PC_write_en),
        .IF_ID_write_en(IF_ID_write_en),
        .IF_ID_flush(IF_ID_flush),
        .ID_EX_write_en(ID_EX_write_en),
        .ID_EX_flush(ID_EX_flush),
        .EX_MEM_write_en(EX_MEM_write_en),
        .MEM_WB_flush(MEM_WB_flush),
        .stall_state(stall_state),
        .timeout(timeout),
        .stall_cycles(stall_cycles),
        .flush_events(flush_events)
    );

    assign ctl = {PC_write_en, IF_ID_write_en, IF_ID_flush, ID_EX_write_en,
                  ID_EX_flush, EX_MEM_write_en, MEM_WB_flush};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic idle();
        ID_rs1 = 5'd0;
        ID_rs2 = 5'd0;
        ID_uses_rs1 = 1'b0;
        ID_uses_rs2 = 1'b0;
        EX_rd = 5'd0;
        EX_mem_read = 1'b0;
        EX_branch_taken = 1'b0;
        imem_busy = 1'b0;
        dmem_busy = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        RESET = 1'b1;
        #1;
        vectors++;
        if (ctl !== C_RST) begin
            miscompares++;
            $display("FAIL rst_ctl got %b want %b", ctl, C_RST);
        end
        @(posedge CLK);
        #1;
        vectors++;
        if ({stall_state, timeout} !== 3'b000 || stall_cycles !== 32'd0
            || flush_events !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_state got st=%0d to=%b sc=%0d fe=%0d want 0",
                     stall_state, timeout, stall_cycles, flush_events);
        end
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        vectors++;
        if (ctl !== C_DEF) begin
            miscompares++;
            $display("FAIL rst_release got %b want %b", ctl, C_DEF);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        EX_mem_read = 1'b1;
        EX_rd = 5'd5;
        ID_rs2 = 5'd5;
        ID_uses_rs2 = 1'b1;
        #1;
        vectors++;
        if (ctl !== C_LU) begin
            miscompares++;
            $display("FAIL lu_rs2 got %b want %b", ctl, C_LU);
        end
        @(posedge CLK);
        #1;
        vectors++;
        if (stall_cycles !== (PERF ? 32'd1 : 32'd0) || stall_state !== 2'd0) begin
            miscompares++;
            $display("FAIL lu_cnt got sc=%0d st=%0d want sc=%0d st=0",
                     stall_cycles, stall_state, PERF ? 1 : 0);
        end
        @(negedge CLK);
        EX_mem_read = 1'b0;
        #1;
        vectors++;
        if (ctl !== C_DEF) begin
            miscompares++;
            $display("FAIL lu_advance got %b want %b", ctl, C_DEF);
        end
        EX_mem_read = 1'b1;
        EX_rd = 5'd0;
        ID_rs2 = 5'd0;
        #1;
        vectors++;
        if (ctl !== C_DEF) begin
            miscompares++;
            $display("FAIL lu_x0 got %b want %b", ctl, C_DEF);
        end
        EX_rd = 5'd7;
        ID_rs1 = 5'd7;
        ID_uses_rs1 = 1'b0;
        ID_uses_rs2 = 1'b0;
        #1;
        vectors++;
        if (ctl !== C_DEF) begin
            miscompares++;
            $display("FAIL lu_unused got %b want %b", ctl, C_DEF);
        end
        ID_uses_rs1 = 1'b1;
        #1;
        vectors++;
        if (ctl !== C_LU) begin
            miscompares++;
            $display("FAIL lu_rs1 got %b want %b", ctl, C_LU);
        end
        @(negedge CLK);
        idle();
    endtask

    task automatic test_branch_load_use();
        do_reset();
        EX_mem_read = 1'b1;
        EX_rd = 5'd9;
        ID_rs1 = 5'd9;
        ID_uses_rs1 = 1'b1;
        EX_branch_taken = 1'b1;
        #1;
        vectors++;
        if (ctl !== C_BR) begin
            miscompares++;
            $display("FAIL br_lu got %b want %b", ctl, C_BR);
        end
        @(posedge CLK);
        #1;
        vectors++;
        if (flush_events !== (PERF ? 32'd1 : 32'd0) || stall_cycles !== 32'd0) begin
            miscompares++;
            $display("FAIL br_cnt got fe=%0d sc=%0d want fe=%0d sc=0",
                     flush_events, stall_cycles, PERF ? 1 : 0);
        end
        @(negedge CLK);
        idle();
    endtask

    task automatic test_dmem_branch();
        do_reset();
        dmem_busy = 1'b1;
        EX_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (ctl !== C_DMEM) begin
                miscompares++;
                $display("FAIL dmem_ctl[%0d] got %b want %b", i, ctl, C_DMEM);
            end
            @(posedge CLK);
            #1;
            vectors++;
            if (stall_state !== 2'd1) begin
                miscompares++;
                $display("FAIL dmem_st[%0d] got %0d want 1", i, stall_state);
            end
            @(negedge CLK);
        end
        dmem_busy = 1'b0;
        #1;
        vectors++;
        if (ctl !== C_BR || stall_state !== 2'd1) begin
            miscompares++;
            $display("FAIL dmem_release got %b st=%0d want %b st=1",
                     ctl, stall_state, C_BR);
        end
        @(posedge CLK);
        #1;
        vectors++;
        if (stall_state !== 2'd0 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL dmem_run got st=%0d to=%b want st=0 to=0",
                     stall_state, timeout);
        end
        vectors++;
        if (stall_cycles !== (PERF ? 32'd3 : 32'd0)
            || flush_events !== (PERF ? 32'd1 : 32'd0)) begin
            miscompares++;
            $display("FAIL dmem_cnt got sc=%0d fe=%0d want sc=%0d fe=%0d",
                     stall_cycles, flush_events, PERF ? 3 : 0, PERF ? 1 : 0);
        end
        @(negedge CLK);
        idle();
    endtask

    task automatic test_priority();
        do_reset();
        dmem_busy = 1'b1;
        imem_busy = 1'b1;
        EX_mem_read = 1'b1;
        EX_rd = 5'd3;
        ID_rs2 = 5'd3;
        ID_uses_rs2 = 1'b1;
        #1;
        vectors++;
        if (ctl !== C_DMEM) begin
            miscompares++;
            $display("FAIL pri_dmem got %b want %b", ctl, C_DMEM);
        end
        dmem_busy = 1'b0;
        #1;
        vectors++;
        if (ctl !== C_LU) begin
            miscompares++;
            $display("FAIL pri_lu got %b want %b", ctl, C_LU);
        end
        EX_mem_read = 1'b0;
        #1;
        vectors++;
        if (ctl !== C_IMEM) begin
            miscompares++;
            $display("FAIL pri_imem got %b want %b", ctl, C_IMEM);
        end
        @(posedge CLK);
        #1;
        vectors++;
        if (stall_state !== 2'd2) begin
            miscompares++;
            $display("FAIL pri_iwait got %0d want 2", stall_state);
        end
        @(negedge CLK);
        dmem_busy = 1'b1;
        @(posedge CLK);
        #1;
        vectors++;
        if (stall_state !== 2'd1) begin
            miscompares++;
            $display("FAIL pri_i2d got %0d want 1", stall_state);
        end
        @(negedge CLK);
        dmem_busy = 1'b0;
        @(posedge CLK);
        #1;
        vectors++;
        if (stall_state !== 2'd2) begin
            miscompares++;
            $display("FAIL pri_d2i got %0d want 2", stall_state);
        end
        @(negedge CLK);
        idle();
    endtask

    task automatic test_imem_timeout();
        do_reset();
        imem_busy = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            #1;
            vectors++;
            if (ctl !== C_IMEM) begin
                miscompares++;
                $display("FAIL imem_ctl[%0d] got %b want %b", i, ctl, C_IMEM);
            end
            @(posedge CLK);
            #1;
            if (i == 10) begin
                vectors++;
                if (timeout !== 1'b0 || stall_state !== 2'd2) begin
                    miscompares++;
                    $display("FAIL imem_early got to=%b st=%0d want to=0 st=2",
                             timeout, stall_state);
                end
            end
            if (i == 17) begin
                vectors++;
                if (timeout !== 1'b1) begin
                    miscompares++;
                    $display("FAIL imem_timeout got %b want 1", timeout);
                end
            end
            @(negedge CLK);
        end
        imem_busy = 1'b0;
        #1;
        vectors++;
        if (ctl !== C_DEF) begin
            miscompares++;
            $display("FAIL imem_drop got %b want %b", ctl, C_DEF);
        end
        @(posedge CLK);
        #1;
        vectors++;
        if (timeout !== 1'b1 || stall_state !== 2'd0
            || stall_cycles !== (PERF ? 32'd20 : 32'd0)) begin
            miscompares++;
            $display("FAIL imem_sticky got to=%b st=%0d sc=%0d want to=1 st=0 sc=%0d",
                     timeout, stall_state, stall_cycles, PERF ? 20 : 0);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid_dwait();
        do_reset();
        dmem_busy = 1'b1;
        EX_branch_taken = 1'b1;
        repeat (18) @(posedge CLK);
        #1;
        vectors++;
        if (timeout !== 1'b1 || stall_state !== 2'd1) begin
            miscompares++;
            $display("FAIL mid_pre got to=%b st=%0d want to=1 st=1",
                     timeout, stall_state);
        end
        #2;
        RESET = 1'b1;
        #1;
        vectors++;
        if (ctl !== C_RST) begin
            miscompares++;
            $display("FAIL mid_ctl got %b want %b", ctl, C_RST);
        end
        vectors++;
        if ({stall_state, timeout} !== 3'b000 || stall_cycles !== 32'd0
            || flush_events !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_state got st=%0d to=%b sc=%0d fe=%0d want 0",
                     stall_state, timeout, stall_cycles, flush_events);
        end
        @(negedge CLK);
        idle();
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        vectors++;
        if (timeout !== 1'b0 || stall_state !== 2'd0) begin
            miscompares++;
            $display("FAIL mid_after got to=%b st=%0d want 0", timeout, stall_state);
        end
    endtask

    initial begin
        idle();
        RESET = 1'b1;
        test_reset();
        test_load_use();
        test_branch_load_use();
        test_dmem_branch();
        test_priority();
        test_imem_timeout();
        test_reset_mid_dwait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage RISC-V pipeline.
- Drives write-enable and flush inputs of PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Handles load-use hazards, taken branches/jumps, and multi-cycle instruction/data memory waits.
- Includes a memory-wait watchdog that flags hung memories.

Parameters:
- MAX_WAIT, 16: consecutive busy cycles before timeout asserts.
- CNT_W, 5: wait counter width; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-high reset.
- ID_rs1, ID_rs2  input  5 each  source registers of the instruction in ID.
- ID_uses_rs1, ID_uses_rs2  input  1 each  the ID instruction actually reads rs1/rs2.
- EX_rd  input  5  destination register of the instruction in EX.
- EX_mem_read  input  1  the EX instruction is a load.
- EX_branch_taken  input  1  taken branch or jump resolved in EX.
- imem_busy  input  1  instruction memory has not returned the fetch.
- dmem_busy  input  1  data memory access in MEM is not complete.
- PC_write_en  output  1  PC load enable.
- IF_ID_write_en  output  1  IF/ID load enable.
- IF_ID_flush  output  1  IF/ID loads NOP/zero.
- ID_EX_write_en  output  1  ID/EX load enable.
- ID_EX_flush  output  1  ID/EX loads bubble.
- EX_MEM_write_en  output  1  EX/MEM load enable.
- MEM_WB_flush  output  1  MEM/WB loads bubble.
- stall_state  output  2  FSM state: 0=RUN, 1=DWAIT, 2=IWAIT.
- timeout  output  1  sticky memory-wait watchdog flag.
- stall_cycles  output  32  count of stall cycles (feature-dependent).
- flush_events  output  32  count of branch flushes (feature-dependent).

Behaviour:
- Control outputs are combinational from inputs, gated by RESET. State, counters and timeout are registers.
- While RESET=1:
  - All *_write_en = 0.
  - IF_ID_flush, ID_EX_flush and MEM_WB_flush = 1.
  - state = RUN, wait_cnt = 0, timeout = 0, perf counters = 0.
- Default (no event): all write_en = 1, all flush = 0.
- Events are applied in strict priority order, one per cycle. Lower-priority events are ignored that cycle; because their inputs stay asserted, they are re-evaluated next cycle.
  1. dmem_busy=1: full freeze.
     - PC, IF_ID, ID_EX and EX_MEM write_en = 0.
     - MEM_WB_flush = 1.
     - Takes precedence over a branch; the branch stays held in EX and is honoured on the release cycle.
  2. EX_branch_taken=1:
     - PC_write_en = 1 (loads target).
     - IF_ID_flush = 1, ID_EX_flush = 1.
     - Penalty is 2 bubbles.
     - Overrides load-use and imem_busy.
  3. Load-use: EX_mem_read=1, EX_rd != 0, and (ID_uses_rs1 and ID_rs1 == EX_rd, or ID_uses_rs2 and ID_rs2 == EX_rd).
     - PC_write_en = 0, IF_ID_write_en = 0, ID_EX_flush = 1.
     - Exactly 1 cycle; the load advances to MEM, which clears the condition.
  4. imem_busy=1:
     - PC_write_en = 0, IF_ID_flush = 1.
     - Downstream stages keep flowing.
- FSM, registered at posedge CLK:
  - RUN -> DWAIT on dmem_busy.
  - RUN -> IWAIT on imem_busy with dmem_busy=0.
  - DWAIT -> RUN when dmem_busy=0. If imem_busy=1 at that point, go to IWAIT instead.
  - IWAIT -> DWAIT if dmem_busy rises.
  - IWAIT -> RUN when imem_busy=0.
  - Code 3 is unused; recover to RUN.
- wait_cnt:
  - Increments each cycle the state is DWAIT or IWAIT and the corresponding busy is still 1.
  - Clears on any state change or on return to RUN.
  - Saturates at MAX_WAIT.
- timeout:
  - Set on the posedge where wait_cnt reaches MAX_WAIT.
  - Stays 1 until RESET; has no effect on control outputs.
- Reset asserted mid-wait: immediate return to reset values, with no glitching of the registered outputs.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cycles increments every cycle in which PC_write_en=0 (RESET=0).
  - flush_events increments once per cycle in which rule 2 fires.
  - Both wrap at 2^32.
- Undefined: both outputs are tied to 0 and no counter flops are synthesised.
- Ports are present in both builds.

Test Plan:
- Load-use: EX_mem_read=1, EX_rd=5, ID_rs2=5, ID_uses_rs2=1 -> PC_write_en=0, IF_ID_write_en=0, ID_EX_flush=1 for 1 cycle. Repeat with EX_rd=0 -> no stall.
- Branch during load-use: EX_branch_taken=1 plus load-use match -> PC_write_en=1, IF_ID_flush=1, ID_EX_flush=1; flush_events +1 with the macro defined.
- dmem_busy high for 3 cycles with EX_branch_taken=1 -> freeze with MEM_WB_flush=1 and stall_state=1 for 3 cycles; on release, branch flush fires, then stall_state=0.
- imem_busy high for 20 cycles with MAX_WAIT=16 -> IF_ID_flush=1 throughout; timeout=1 after cycle 16 and stays 1 after imem_busy drops, until RESET.
- Async RESET asserted mid-DWAIT -> outputs immediately go to reset values: write_en=0, flushes=1, stall_state=0, timeout=0, counters=0.
- Macro undefined build: stall_cycles = flush_events = 0 under all of the above stimuli.
